// File: rtl/dmem_responder.sv
// Data-memory responder: slave end of the core's load/store channel.
// One request is accepted at a time. The access is committed a fixed number
// of cycles later, and the result is held on the response channel until the
// initiator takes it. Accesses can be byte, half or word, with RISC-V lane
// steering and sign/zero extension on loads.
module dmem_responder #(
  parameter int          DEPTH_WORDS = 256,
  parameter int          LATENCY     = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_error
);

  localparam int          IDX_W  = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [32:0] SPAN   = 33'(DEPTH_WORDS) * 33'd4;
  localparam logic [3:0]  LAT_M1 = 4'(LATENCY - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic        error_q, error_d;

  logic        write_q;
  logic [31:0] addr_q;
  logic [2:0]  funct3_q;
  logic [31:0] wdata_q;

  logic [31:0] mem [DEPTH_WORDS];

  logic [31:0]      offset;
  logic [1:0]       lane;
  logic [IDX_W-1:0] wordIdx;
  logic             outOfRange;
  logic             misaligned;
  logic             badFunct;
  logic             accessErr;
  logic             commit;
  logic [31:0]      memWord;
  logic [7:0]       selByte;
  logic [15:0]      selHalf;
  logic [31:0]      loadData;
  logic [3:0]       byteEn;
  logic [31:0]      storeData;

  assign req_ready = (state_q == ST_IDLE) && !reset;
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_error = error_q;

  // Decode the registered request: address translation, fault detection,
  // load extraction and store byte steering.
  always_comb begin
    offset     = addr_q - BASE_ADDR;
    lane       = offset[1:0];
    wordIdx    = offset[IDX_W+1:2];
    outOfRange = ({1'b0, offset} >= SPAN);
    misaligned = ((funct3_q[1:0] == 2'b01) && lane[0]) ||
                 ((funct3_q[1:0] == 2'b10) && (lane != 2'b00));
    if (write_q) begin
      badFunct = (funct3_q > 3'd2);
    end else begin
      badFunct = (funct3_q == 3'd3) || (funct3_q == 3'd6) || (funct3_q == 3'd7);
    end
    accessErr = outOfRange || misaligned || badFunct;
    commit    = (state_q == ST_WAIT) && (cnt_q == 4'd0);

    memWord = mem[wordIdx];
    selByte = memWord[{lane, 3'b000} +: 8];
    selHalf = memWord[{lane[1], 4'b0000} +: 16];
    case (funct3_q)
      3'd0:    loadData = {{24{selByte[7]}}, selByte};
      3'd1:    loadData = {{16{selHalf[15]}}, selHalf};
      3'd4:    loadData = {24'd0, selByte};
      3'd5:    loadData = {16'd0, selHalf};
      default: loadData = memWord;
    endcase

    case (funct3_q)
      3'd0: begin
        byteEn    = 4'b0001 << lane;
        storeData = {4{wdata_q[7:0]}};
      end
      3'd1: begin
        byteEn    = 4'b0011 << lane;
        storeData = {2{wdata_q[15:0]}};
      end
      default: begin
        byteEn    = 4'b1111;
        storeData = wdata_q;
      end
    endcase
  end

  // Next-state logic: accept in IDLE, count down in WAIT, hold in RESP.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    error_d = error_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          state_d = ST_WAIT;
          cnt_d   = LAT_M1;
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_RESP;
          error_d = accessErr;
          rdata_d = (accessErr || write_q) ? 32'd0 : loadData;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control and response registers; reset drops any pending request.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      rdata_q <= 32'd0;
      error_q <= 32'd0 != 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      error_q <= error_d;
    end
  end

  // Capture the request fields at the acceptance edge.
  always_ff @(posedge clk) begin
    if (!reset && (state_q == ST_IDLE) && req_valid) begin
      write_q  <= req_write;
      addr_q   <= req_addr;
      funct3_q <= req_funct3;
      wdata_q  <= req_wdata;
    end
  end

  // Store commit on the edge that raises rsp_valid; faulted or reset-aborted
  // stores never touch the array.
  always_ff @(posedge clk) begin
    if (!reset && commit && write_q && !accessErr) begin
      for (int b = 0; b < 4; b++) begin
        if (byteEn[b]) begin
          mem[wordIdx][b*8 +: 8] <= storeData[b*8 +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: one instance at LATENCY=1 for the
// functional access tests, one at LATENCY=4 for timing, back-pressure and
// reset-abort behaviour.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        reqWrite;
  logic [31:0] reqAddr;
  logic [2:0]  reqFunct3;
  logic [31:0] reqWdata;
  logic        rspReady;

  logic        reqValid1, reqValid4;
  logic        reqReady1, reqReady4;
  logic        rspValid1, rspValid4;
  logic [31:0] rspRdata1, rspRdata4;
  logic        rspError1, rspError4;

  int          sel;
  logic        curReqReady, curRspValid, curRspError;
  logic [31:0] curRspRdata;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(256), .LATENCY(1), .BASE_ADDR(32'h0)) u1 (
    .clk(clk), .reset(reset),
    .req_valid(reqValid1), .req_ready(reqReady1), .req_write(reqWrite),
    .req_addr(reqAddr), .req_funct3(reqFunct3), .req_wdata(reqWdata),
    .rsp_valid(rspValid1), .rsp_ready(rspReady), .rsp_rdata(rspRdata1),
    .rsp_error(rspError1)
  );

  dmem_responder #(.DEPTH_WORDS(256), .LATENCY(4), .BASE_ADDR(32'h0)) u4 (
    .clk(clk), .reset(reset),
    .req_valid(reqValid4), .req_ready(reqReady4), .req_write(reqWrite),
    .req_addr(reqAddr), .req_funct3(reqFunct3), .req_wdata(reqWdata),
    .rsp_valid(rspValid4), .rsp_ready(rspReady), .rsp_rdata(rspRdata4),
    .rsp_error(rspError4)
  );

  // Route the instance under test onto a common set of observation signals.
  always_comb begin
    if (sel == 4) begin
      curReqReady = reqReady4;
      curRspValid = rspValid4;
      curRspRdata = rspRdata4;
      curRspError = rspError4;
    end else begin
      curReqReady = reqReady1;
      curRspValid = rspValid1;
      curRspRdata = rspRdata1;
      curRspError = rspError1;
    end
  end

  // Single comparison point for the whole bench.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: observed 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Issue one request and wait (bounded) for rsp_valid; rsp_ready stays low.
  task automatic applyStimulus(input int which, input logic w, input logic [31:0] a,
                               input logic [2:0] f3, input logic [31:0] wd,
                               output int edges, output logic sawReady);
    int waited;
    sel = which;
    @(negedge clk);
    reqWrite  = w;
    reqAddr   = a;
    reqFunct3 = f3;
    reqWdata  = wd;
    rspReady  = 1'b0;
    if (which == 4) reqValid4 = 1'b1; else reqValid1 = 1'b1;
    waited = 0;
    while (!curReqReady && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    @(posedge clk);
    #1;
    reqValid1 = 1'b0;
    reqValid4 = 1'b0;
    reqAddr   = 32'hFFFF_FFFC;
    reqWdata  = 32'h5A5A_5A5A;
    edges     = 0;
    sawReady  = 1'b0;
    while (!curRspValid && edges <= 40) begin
      if (curReqReady) sawReady = 1'b1;
      @(posedge clk);
      #1;
      edges++;
    end
  endtask

  // Complete the response handshake in one cycle.
  task automatic finishResponse;
    rspReady = 1'b1;
    @(posedge clk);
    #1;
    rspReady = 1'b0;
  endtask

  // Full transaction with latency, data and error checks.
  task automatic doAccess(input string tag, input int which, input logic w,
                          input logic [31:0] a, input logic [2:0] f3,
                          input logic [31:0] wd, input int expLat,
                          input logic [31:0] expData, input logic expErr);
    int   edges;
    logic sawReady;
    applyStimulus(which, w, a, f3, wd, edges, sawReady);
    checkOutput({tag, " latency"}, 32'(edges), 32'(expLat));
    checkOutput({tag, " rdata"}, curRspRdata, expData);
    checkOutput({tag, " error"}, {31'd0, curRspError}, {31'd0, expErr});
    finishResponse();
  endtask

  initial begin
    int   edges;
    logic sawReady;
    logic sawValid;

    reset     = 1'b1;
    reqValid1 = 1'b0;
    reqValid4 = 1'b0;
    reqWrite  = 1'b0;
    reqAddr   = 32'd0;
    reqFunct3 = 3'd0;
    reqWdata  = 32'd0;
    rspReady  = 1'b0;
    sel       = 1;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset rsp_valid", {31'd0, rspValid1}, 32'd0);
    checkOutput("reset rsp_rdata", rspRdata1, 32'd0);
    checkOutput("reset rsp_error", {31'd0, rspError4}, 32'd0);
    checkOutput("reset req_ready", {31'd0, reqReady1}, 32'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("idle req_ready", {31'd0, reqReady1}, 32'd1);

    doAccess("SW 0x10",  1, 1'b1, 32'h10, 3'd2, 32'h8899AABB, 1, 32'h0,        1'b0);
    doAccess("LW 0x10",  1, 1'b0, 32'h10, 3'd2, 32'h0,        1, 32'h8899AABB, 1'b0);
    doAccess("LB 0x13",  1, 1'b0, 32'h13, 3'd0, 32'h0,        1, 32'hFFFFFF88, 1'b0);
    doAccess("LBU 0x13", 1, 1'b0, 32'h13, 3'd4, 32'h0,        1, 32'h00000088, 1'b0);
    doAccess("LH 0x10",  1, 1'b0, 32'h10, 3'd1, 32'h0,        1, 32'hFFFFAABB, 1'b0);
    doAccess("LHU 0x12", 1, 1'b0, 32'h12, 3'd5, 32'h0,        1, 32'h00008899, 1'b0);
    doAccess("SB 0x11",  1, 1'b1, 32'h11, 3'd0, 32'hFFFFFFCC, 1, 32'h0,        1'b0);
    doAccess("LW after SB", 1, 1'b0, 32'h10, 3'd2, 32'h0,     1, 32'h8899CCBB, 1'b0);
    doAccess("SH 0x12",  1, 1'b1, 32'h12, 3'd1, 32'hABCD1234, 1, 32'h0,        1'b0);
    doAccess("LW after SH", 1, 1'b0, 32'h10, 3'd2, 32'h0,     1, 32'h1234CCBB, 1'b0);

    doAccess("LW misaligned", 1, 1'b0, 32'h12,  3'd2, 32'h0,    1, 32'h0, 1'b1);
    doAccess("SH misaligned", 1, 1'b1, 32'h11,  3'd1, 32'hFFFF, 1, 32'h0, 1'b1);
    doAccess("LW after bad SH", 1, 1'b0, 32'h10, 3'd2, 32'h0,   1, 32'h1234CCBB, 1'b0);
    doAccess("LW out of range", 1, 1'b0, 32'h400, 3'd2, 32'h0,  1, 32'h0, 1'b1);
    doAccess("load funct3=3", 1, 1'b0, 32'h10,  3'd3, 32'h0,    1, 32'h0, 1'b1);
    doAccess("store funct3=3", 1, 1'b1, 32'h10, 3'd3, 32'h0,    1, 32'h0, 1'b1);
    doAccess("LW after bad store", 1, 1'b0, 32'h10, 3'd2, 32'h0, 1, 32'h1234CCBB, 1'b0);

    doAccess("L4 SW 0x20", 4, 1'b1, 32'h20, 3'd2, 32'h11223344, 4, 32'h0, 1'b0);

    applyStimulus(4, 1'b0, 32'h20, 3'd2, 32'h0, edges, sawReady);
    checkOutput("L4 LW latency", 32'(edges), 32'd4);
    checkOutput("L4 req_ready in WAIT", {31'd0, sawReady}, 32'd0);
    checkOutput("L4 LW rdata", curRspRdata, 32'h11223344);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      checkOutput("L4 hold rsp_valid", {31'd0, curRspValid}, 32'd1);
      checkOutput("L4 hold rdata", curRspRdata, 32'h11223344);
      checkOutput("L4 hold req_ready", {31'd0, curReqReady}, 32'd0);
    end
    finishResponse();
    checkOutput("L4 rsp_valid after handshake", {31'd0, curRspValid}, 32'd0);
    checkOutput("L4 req_ready after handshake", {31'd0, curReqReady}, 32'd1);

    sel = 4;
    @(negedge clk);
    reqWrite  = 1'b1;
    reqAddr   = 32'h20;
    reqFunct3 = 3'd2;
    reqWdata  = 32'hDEADBEEF;
    reqValid4 = 1'b1;
    @(posedge clk);
    #1;
    reqValid4 = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    sawValid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (curRspValid) sawValid = 1'b1;
      @(posedge clk);
      #1;
    end
    checkOutput("aborted store rsp_valid", {31'd0, sawValid}, 32'd0);
    checkOutput("req_ready after reset", {31'd0, curReqReady}, 32'd1);
    doAccess("LW after aborted SW", 4, 1'b0, 32'h20, 3'd2, 32'h0, 4, 32'h11223344, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  // Safety net in case a handshake wait goes wrong.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
